// File: rtl/tile_scheduler_if.sv
// Tile command channel: valid/ready handshake plus the tile payload (start indices, extents, psum flags).
interface tile_scheduler_if;
    logic        tile_valid_o;
    logic        tile_ready_i;
    logic [6:0]  r_idx_o;
    logic [10:0] k_idx_o;
    logic [10:0] d_idx_o;
    logic [6:0]  cur_R_o;
    logic [6:0]  cur_K_o;
    logic [6:0]  cur_D_o;
    logic        first_d_o;
    logic        last_d_o;

    modport master (
        output tile_valid_o, r_idx_o, k_idx_o, d_idx_o,
        output cur_R_o, cur_K_o, cur_D_o, first_d_o, last_d_o,
        input  tile_ready_i
    );

    modport slave (
        input  tile_valid_o, r_idx_o, k_idx_o, d_idx_o,
        input  cur_R_o, cur_K_o, cur_D_o, first_d_o, last_d_o,
        output tile_ready_i
    );
endinterface

// File: rtl/tile_scheduler.sv
// Walks the r/k/d tile loops of one layer and issues one tile command per handshake.
// Define TILE_SCHED_PERF_EN to add the accepted-tile and stall-cycle counters.
module tile_scheduler #(
    parameter int TILE_R_MAX = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       layer_type_i,
    input  logic [10:0]      in_D_i,
    input  logic [10:0]      out_K_i,
    input  logic [6:0]       out_R_i,
    input  logic [6:0]       tile_D_i,
    input  logic [6:0]       tile_K_i,
    input  logic [31:0]      tile_n_i,
    tile_scheduler_if.master tile,
    output logic             busy_o,
    output logic             done_o
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] tile_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    localparam logic [1:0] LT_DW = 2'd1;

    if (TILE_R_MAX < 1 || CNT_W < 1) begin : g_param_check
        $error("tile_scheduler: TILE_R_MAX and CNT_W must be positive");
    end

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    typedef struct packed {
        logic        dw;
        logic [10:0] in_d;
        logic [10:0] out_k;
        logic [6:0]  out_r;
        logic [6:0]  tile_d;
        logic [6:0]  tile_k;
        logic [6:0]  rows;
    } cfg_t;

    state_t      state_q;
    cfg_t        cfg_live, cfg_q, cfg;
    logic [6:0]  rows_live;
    logic        cfg_zero;
    logic [10:0] d_q;
    logic [6:0]  r_n;
    logic [10:0] k_n, d_n;
    logic [7:0]  r_sum;
    logic [11:0] k_sum, d_sum, d_end;
    logic [6:0]  r_left;
    logic [10:0] k_left, d_left;
    logic [6:0]  cur_r_n, cur_k_n, cur_d_n;
    logic        r_wrap, k_wrap, d_wrap, last_tile, hs, load_go, step_go;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rows_live = out_R_i;
        if ({25'd0, rows_live} > 32'(TILE_R_MAX)) rows_live = 7'(TILE_R_MAX);
        if ({25'd0, rows_live} > tile_n_i)        rows_live = tile_n_i[6:0];

        cfg_live.dw     = (layer_type_i == LT_DW);
        cfg_live.in_d   = in_D_i;
        cfg_live.out_k  = out_K_i;
        cfg_live.out_r  = out_R_i;
        cfg_live.tile_d = tile_D_i;
        cfg_live.tile_k = tile_K_i;
        cfg_live.rows   = rows_live;

        cfg_zero = (in_D_i == '0) || (out_K_i == '0) || (out_R_i == '0) ||
                   (tile_D_i == '0) || (tile_K_i == '0) || (rows_live == '0);
    end

    // The LOAD cycle builds tile 0 straight from the inputs being latched.
    always_comb begin
        cfg = (state_q == LOAD) ? cfg_live : cfg_q;
        hs  = tile.tile_valid_o && tile.tile_ready_i;

        // 12-bit sums: idx + step can exceed the 11-bit totals and must not wrap.
        r_sum  = {1'b0, tile.r_idx_o} + {1'b0, cfg.rows};
        k_sum  = {1'b0, tile.k_idx_o} + {5'd0, cfg.tile_k};
        d_sum  = {1'b0, d_q} + {5'd0, cfg.tile_d};
        r_wrap = (r_sum >= {1'b0, cfg.out_r});
        k_wrap = (k_sum >= {1'b0, cfg.out_k});
        d_wrap = cfg.dw || (d_sum >= {1'b0, cfg.in_d});
        last_tile = r_wrap && k_wrap && d_wrap;

        r_n = tile.r_idx_o;
        k_n = tile.k_idx_o;
        d_n = d_q;
        if (state_q == LOAD) begin
            r_n = '0;
            k_n = '0;
            d_n = '0;
        end else if (!d_wrap) begin
            d_n = d_sum[10:0];
        end else begin
            d_n = '0;
            if (!k_wrap) begin
                k_n = k_sum[10:0];
            end else begin
                k_n = '0;
                r_n = r_sum[6:0];
            end
        end

        r_left  = cfg.out_r - r_n;
        k_left  = cfg.out_k - k_n;
        d_left  = cfg.in_d - d_n;
        cur_r_n = (cfg.rows < r_left) ? cfg.rows : r_left;
        cur_k_n = ({4'd0, cfg.tile_k} < k_left) ? cfg.tile_k : k_left[6:0];
        cur_d_n = cfg.dw ? cur_k_n :
                  (({4'd0, cfg.tile_d} < d_left) ? cfg.tile_d : d_left[6:0]);
        d_end   = {1'b0, d_n} + {5'd0, cur_d_n};

        load_go = (state_q == LOAD)  && !abort_i && !cfg_zero;
        step_go = (state_q == ISSUE) && !abort_i && hs && !last_tile;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cfg_q             <= '0;
            tile.tile_valid_o <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOAD;
                        busy_o  <= 1'b1;
                    end
                end
                LOAD: begin
                    cfg_q <= cfg_live;
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (cfg_zero) begin
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end else begin
                        state_q           <= ISSUE;
                        tile.tile_valid_o <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (abort_i) begin
                        state_q           <= IDLE;
                        busy_o            <= 1'b0;
                        tile.tile_valid_o <= 1'b0;
                    end else if (hs && last_tile) begin
                        state_q           <= DONE;
                        tile.tile_valid_o <= 1'b0;
                        done_o            <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // The registered payload doubles as the r/k loop state; d keeps its own index for DW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q            <= '0;
            tile.r_idx_o   <= '0;
            tile.k_idx_o   <= '0;
            tile.d_idx_o   <= '0;
            tile.cur_R_o   <= '0;
            tile.cur_K_o   <= '0;
            tile.cur_D_o   <= '0;
            tile.first_d_o <= 1'b0;
            tile.last_d_o  <= 1'b0;
        end else if (load_go || step_go) begin
            d_q            <= d_n;
            tile.r_idx_o   <= r_n;
            tile.k_idx_o   <= k_n;
            tile.d_idx_o   <= cfg.dw ? k_n : d_n;
            tile.cur_R_o   <= cur_r_n;
            tile.cur_K_o   <= cur_k_n;
            tile.cur_D_o   <= cur_d_n;
            tile.first_d_o <= cfg.dw || (d_n == '0);
            tile.last_d_o  <= cfg.dw || (d_end == {1'b0, cfg.in_d});
        end
    end

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else if (state_q == IDLE && start_i) begin
            tile_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (hs && !abort_i && tile_cnt_o != '1)
                tile_cnt_o <= tile_cnt_o + CNT_W'(1);
            if (tile.tile_valid_o && !tile.tile_ready_i && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler: a nested-loop tile list model is the reference.
// Counter checks are compiled in when TILE_SCHED_PERF_EN is defined.
module tb_tile_scheduler;

    localparam int TILE_R_MAX_TB = 64;

    typedef struct {
        int lt;
        int in_d;
        int out_k;
        int out_r;
        int tile_d;
        int tile_k;
        bit [31:0] tile_n;
    } lcfg_t;

    typedef struct {
        int r; int k; int d;
        int cr; int ck; int cd;
        bit first; bit last;
    } tile_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, abort_i;
    logic [1:0]  layer_type_i;
    logic [10:0] in_D_i, out_K_i;
    logic [6:0]  out_R_i, tile_D_i, tile_K_i;
    logic [31:0] tile_n_i;
    logic        busy_o, done_o;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0] tile_cnt_o, stall_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    tile_t exp_q[$];

    tile_scheduler_if tif ();

    tile_scheduler #(.TILE_R_MAX(TILE_R_MAX_TB), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .layer_type_i (layer_type_i),
        .in_D_i       (in_D_i),
        .out_K_i      (out_K_i),
        .out_R_i      (out_R_i),
        .tile_D_i     (tile_D_i),
        .tile_K_i     (tile_K_i),
        .tile_n_i     (tile_n_i),
        .tile         (tif),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef TILE_SCHED_PERF_EN
        ,
        .tile_cnt_o   (tile_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic int min2(input longint a, input longint b);
        return int'((a < b) ? a : b);
    endfunction

    function automatic lcfg_t mk_cfg(input int lt, input int in_d, input int out_k, input int out_r,
                                     input int tile_d, input int tile_k, input bit [31:0] tile_n);
        lcfg_t c;
        c.lt = lt; c.in_d = in_d; c.out_k = out_k; c.out_r = out_r;
        c.tile_d = tile_d; c.tile_k = tile_k; c.tile_n = tile_n;
        return c;
    endfunction

    // Reference: the full ordered tile list for one layer, straight from the loop rules.
    function automatic void build_model(input lcfg_t c);
        longint rows;
        tile_t  t;
        exp_q.delete();
        rows = c.tile_n;
        if (rows > TILE_R_MAX_TB) rows = TILE_R_MAX_TB;
        if (rows > c.out_r)       rows = c.out_r;
        if (c.in_d == 0 || c.out_k == 0 || c.out_r == 0 || c.tile_d == 0 ||
            c.tile_k == 0 || rows == 0) return;
        for (int r = 0; r < c.out_r; r += int'(rows)) begin
            for (int k = 0; k < c.out_k; k += c.tile_k) begin
                t.r  = r;
                t.k  = k;
                t.cr = min2(rows, c.out_r - r);
                t.ck = min2(c.tile_k, c.out_k - k);
                if (c.lt == 1) begin
                    t.d = k; t.cd = t.ck; t.first = 1'b1; t.last = 1'b1;
                    exp_q.push_back(t);
                end else begin
                    for (int d = 0; d < c.in_d; d += c.tile_d) begin
                        t.d     = d;
                        t.cd    = min2(c.tile_d, c.in_d - d);
                        t.first = (d == 0);
                        t.last  = (d + t.cd == c.in_d);
                        exp_q.push_back(t);
                    end
                end
            end
        end
    endfunction

    task automatic drive_cfg(input lcfg_t c);
        layer_type_i = 2'(c.lt);
        in_D_i       = 11'(c.in_d);
        out_K_i      = 11'(c.out_k);
        out_R_i      = 7'(c.out_r);
        tile_D_i     = 7'(c.tile_d);
        tile_K_i     = 7'(c.tile_k);
        tile_n_i     = c.tile_n;
    endtask

    task automatic scramble_cfg();
        layer_type_i = 2'($urandom);
        in_D_i       = 11'($urandom);
        out_K_i      = 11'($urandom);
        out_R_i      = 7'($urandom);
        tile_D_i     = 7'($urandom);
        tile_K_i     = 7'($urandom);
        tile_n_i     = $urandom;
    endtask

    task automatic check_tile(input int idx);
        tile_t t;
        t = exp_q[idx];
        check($sformatf("r_idx[%0d]", idx), 64'(tif.r_idx_o), 64'(t.r));
        check($sformatf("k_idx[%0d]", idx), 64'(tif.k_idx_o), 64'(t.k));
        check($sformatf("d_idx[%0d]", idx), 64'(tif.d_idx_o), 64'(t.d));
        check($sformatf("cur_R[%0d]", idx), 64'(tif.cur_R_o), 64'(t.cr));
        check($sformatf("cur_K[%0d]", idx), 64'(tif.cur_K_o), 64'(t.ck));
        check($sformatf("cur_D[%0d]", idx), 64'(tif.cur_D_o), 64'(t.cd));
        check($sformatf("first_d[%0d]", idx), 64'(tif.first_d_o), 64'(t.first));
        check($sformatf("last_d[%0d]", idx), 64'(tif.last_d_o), 64'(t.last));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(tif.tile_valid_o), 0);
        check({tag, "_busy"},  64'(busy_o), 0);
        check({tag, "_done"},  64'(done_o), 0);
        check({tag, "_idx"},   {tif.r_idx_o, tif.k_idx_o, tif.d_idx_o}, 0);
        check({tag, "_cur"},   {tif.cur_R_o, tif.cur_K_o, tif.cur_D_o}, 0);
        check({tag, "_flags"}, {tif.first_d_o, tif.last_d_o}, 0);
`ifdef TILE_SCHED_PERF_EN
        check({tag, "_tile_cnt"},  64'(tile_cnt_o), 0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt_o), 0);
`endif
    endtask

    // One layer: start, then accept tiles until the DUT drops valid, checking each against the model.
    // abort_at >= 0 aborts (with ready high) once that many tiles were accepted.
    task automatic run_layer(input lcfg_t c, input int ready_pct, input int abort_at,
                             input int stall_tile, input int stall_len, input bit noise);
        int n, idx, stalls, stall_done, budget;
        bit rdy;
        build_model(c);
        n = exp_q.size();
        @(negedge clk);
        drive_cfg(c);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("load_valid", 64'(tif.tile_valid_o), 0);
        check("load_busy", 64'(busy_o), 1);
`ifdef TILE_SCHED_PERF_EN
        check("start_clear_cnt", {tile_cnt_o, stall_cnt_o}, 0);
`endif
        @(negedge clk);
        if (noise) scramble_cfg();
        check("first_valid_lat", 64'(tif.tile_valid_o), 64'(n != 0));
        check("zero_done_lat", 64'(done_o), 64'(n == 0));
        if (n == 0) begin
            @(negedge clk);
            check("zero_idle_busy", 64'(busy_o), 0);
            check("zero_idle_valid", 64'(tif.tile_valid_o), 0);
            return;
        end
        idx = 0; stalls = 0; stall_done = 0;
        budget = 20 * n + 50;
        while (budget > 0 && tif.tile_valid_o === 1'b1) begin
            check("busy_in_issue", 64'(busy_o), 1);
            check("done_early", 64'(done_o), 0);
            check("tile_overrun", 64'(idx < n), 1);
            if (idx < n) check_tile(idx);
            if (idx == abort_at) begin
                abort_i = 1'b1;
                tif.tile_ready_i = 1'b1;
                @(negedge clk);
                abort_i = 1'b0;
                tif.tile_ready_i = 1'b0;
                check("abort_valid", 64'(tif.tile_valid_o), 0);
                check("abort_busy", 64'(busy_o), 0);
                check("abort_done", 64'(done_o), 0);
                @(negedge clk);
                check("abort_no_done", 64'(done_o), 0);
                return;
            end
            if (stall_len > 0) begin
                rdy = !(idx == stall_tile && stall_done < stall_len);
                if (!rdy) stall_done++;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            tif.tile_ready_i = rdy;
            if (rdy) idx++;
            else     stalls++;
            if (noise) begin
                start_i = ($urandom_range(7) == 0);
                scramble_cfg();
            end
            @(negedge clk);
            start_i = 1'b0;
            budget--;
        end
        tif.tile_ready_i = 1'b0;
        check("layer_budget", 64'(budget > 0), 1);
        check("tile_count", 64'(idx), 64'(n));
        check("done_after_last", 64'(done_o), 1);
        check("busy_in_done", 64'(busy_o), 1);
`ifdef TILE_SCHED_PERF_EN
        check("tile_cnt", 64'(tile_cnt_o), 64'(n));
        check("stall_cnt", 64'(stall_cnt_o), 64'(stalls));
        if (stall_len > 0) check("stall_cnt_directed", 64'(stall_cnt_o), 64'(stall_len));
`endif
        @(negedge clk);
        check("done_pulse_width", 64'(done_o), 0);
        check("idle_busy", 64'(busy_o), 0);
    endtask

    initial begin
        lcfg_t c;
        rst_n = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        tif.tile_ready_i = 1'b0;
        drive_cfg(mk_cfg(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check_zero_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // PW 64x96x14, 32/32 tiles, 8 rows -> 12 tiles, rows 8 then 6
        run_layer(mk_cfg(0, 64, 96, 14, 32, 32, 8), 100, -1, 0, 0, 1'b0);
        // DW 40 channels, tile_K 10, 7 rows -> 4 tiles
        run_layer(mk_cfg(1, 40, 40, 7, 10, 10, 16), 100, -1, 0, 0, 1'b0);
        // K remainder: cur_K 32, 32, 6
        run_layer(mk_cfg(0, 32, 70, 4, 32, 32, 4), 100, -1, 0, 0, 1'b0);
        // ready low 5 cycles on tile 1
        run_layer(mk_cfg(0, 64, 96, 14, 32, 32, 8), 100, -1, 1, 5, 1'b0);
        // zero-size layer
        run_layer(mk_cfg(0, 64, 0, 14, 32, 32, 8), 100, -1, 0, 0, 1'b0);
        // abort after 3 tiles, then a clean rerun from (0,0,0)
        run_layer(mk_cfg(0, 64, 96, 14, 32, 32, 8), 100, 3, 0, 0, 1'b0);
        run_layer(mk_cfg(0, 64, 96, 14, 32, 32, 8), 100, -1, 0, 0, 1'b0);
        // row clamp at TILE_R_MAX, and full-width channel counts
        run_layer(mk_cfg(2, 20, 20, 100, 16, 16, 1000), 70, -1, 0, 0, 1'b1);
        run_layer(mk_cfg(3, 2047, 2047, 1, 127, 127, 32'hFFFF_FFFF), 100, -1, 0, 0, 1'b0);

        // reset in the middle of a layer must discard all progress
        drive_cfg(mk_cfg(0, 64, 96, 14, 32, 32, 8));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        tif.tile_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_valid", 64'(tif.tile_valid_o), 0);
            check("post_reset_busy", 64'(busy_o), 0);
        end
        tif.tile_ready_i = 1'b0;
        run_layer(mk_cfg(0, 64, 96, 14, 32, 32, 8), 100, -1, 0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            c.lt     = int'($urandom_range(3));
            c.in_d   = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(1, 100));
            c.out_k  = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(1, 100));
            c.out_r  = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(1, 12));
            c.tile_d = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(12, 64));
            c.tile_k = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(12, 64));
            case ($urandom_range(3))
                0:       c.tile_n = $urandom_range(2, 20);
                1:       c.tile_n = $urandom_range(100, 5000);
                2:       c.tile_n = 32'hFFFF_FFFF;
                default: c.tile_n = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(2, 12));
            endcase
            run_layer(c, int'($urandom_range(40, 100)), -1, 0, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter TILE_R_MAX, default 64, the upper clamp on output rows per tile.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle request to schedule the decoded layer.
REQ-006 SHALL have port abort_i, input, 1 bit: synchronous cancel of the current layer.
REQ-007 SHALL have port layer_type_i, input, 2 bits: 0=PW, 1=DW, 2=STD, 3=LIN.
REQ-008 SHALL have ports in_D_i and out_K_i, input, 11 bits each: input and output channel counts.
REQ-009 SHALL have port out_R_i, input, 7 bits: output row count.
REQ-010 SHALL have ports tile_D_i and tile_K_i, input, 7 bits each: channel tile sizes.
REQ-011 SHALL have port tile_n_i, input, 32 bits: maximum rows per tile.
REQ-012 SHALL have ports tile_valid_o (output, 1) and tile_ready_i (input, 1): the tile command handshake.
REQ-013 SHALL have ports r_idx_o (output, 7), k_idx_o (output, 11) and d_idx_o (output, 11): tile start row and start channels.
REQ-014 SHALL have ports cur_R_o (output, 7), cur_K_o (output, 7) and cur_D_o (output, 7): actual tile extents.
REQ-015 SHALL have ports first_d_o and last_d_o (output, 1 each): clear psum on first, write back on last.
REQ-016 SHALL have ports busy_o and done_o (output, 1 each): layer active, and a one-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, ISSUE and DONE.
REQ-018 SHALL, in IDLE, move to LOAD on start_i; start_i SHALL be ignored in every other state.
REQ-019 SHALL, in LOAD, latch all config inputs and compute rows = min(tile_n_i, TILE_R_MAX, out_R_i); later input changes SHALL have no effect until the next start.
REQ-020 SHALL go from LOAD to DONE without asserting tile_valid_o if any of in_D, out_K, out_R, tile_D, tile_K or rows is zero; otherwise it SHALL go to ISSUE.
REQ-021 SHALL assert tile_valid_o throughout ISSUE, with the first tile_valid_o exactly 2 cycles after start_i.
REQ-022 SHALL hold the payload stable while tile_valid_o=1 and tile_ready_i=0, and SHALL advance only on tile_valid_o && tile_ready_i.
REQ-023 SHALL use the loop order r (outer), k, d (inner), with r step rows, k step tile_K and d step tile_D.
REQ-024 SHALL compute each cur_* as min(step, total - idx), so the final tile of each loop carries the remainder.
REQ-025 SHALL set first_d_o=1 when d_idx_o=0 and last_d_o=1 when d_idx_o+cur_D_o=in_D.
REQ-026 SHALL, for DW, skip the d loop: d_idx_o=k_idx_o, cur_D_o=cur_K_o and first_d_o=last_d_o=1.
REQ-027 SHALL go to DONE on the handshake of the final tile, pulse done_o for one cycle there, then return to IDLE.
REQ-028 SHALL, on abort_i in any non-IDLE state, return to IDLE the next cycle, drop tile_valid_o and not pulse done_o; abort_i SHALL take priority over a same-cycle handshake.
REQ-029 SHALL compute loop bounds at 12 bits so that idx+step never wraps.
REQ-030 SHALL assert busy_o in every state other than IDLE.

Reset
REQ-031 SHALL, with rst_n=0, enter IDLE and drive every output to 0, including the counters.
REQ-032 SHALL, on reset mid-layer, discard all progress; no tile SHALL be reissued after reset is released.

Configuration
REQ-033 SHALL, with TILE_SCHED_PERF_EN defined, add outputs tile_cnt_o[CNT_W-1:0] (accepted tiles) and stall_cnt_o[CNT_W-1:0] (cycles with valid && !ready); both SHALL clear on start and saturate at all-ones.
REQ-034 SHALL, with TILE_SCHED_PERF_EN undefined, omit both ports and counters, leaving behaviour otherwise identical.

Verification
REQ-035 SHALL cover PW, in_D=64, out_K=96, out_R=14, tile 32/32, tile_n=8, ready=1 -> 12 tiles; cur_R sequence 8 then 6; first tile (0,0,0) has first_d=1, last_d=0; done 1 cycle after the 12th handshake.
REQ-036 SHALL cover DW, in_D=out_K=40, tile_K=10, out_R=7, tile_n=16 -> 4 tiles, cur_R=7, cur_D=cur_K=10, first_d=last_d=1 on each.
REQ-037 SHALL cover PW, out_K=70, in_D=32, tile_K=32 -> cur_K sequence 32, 32, 6 with k_idx 0, 32, 64.
REQ-038 SHALL cover tile_ready_i held low 5 cycles on tile 1 -> payload unchanged and stall_cnt_o=5 (perf build).
REQ-039 SHALL cover out_K=0 -> done_o 2 cycles after start and tile_valid_o never asserted.
REQ-040 SHALL cover abort_i after 3 tiles -> IDLE next cycle, no done_o; a fresh start then reissues from (0,0,0).
